btn_instr_capture: RTL

//   Front end of the bit-serial CPU: synchronises and debounces the raw step button, latches the
//   16-bit switch instruction on each accepted press, and issues a one-cycle btn_edge with opcode/instr.

---
 rtl/btn_instr_capture.sv | 123 ++++++++++++
 1 files changed

// File: rtl/btn_instr_capture.sv
// Step-button front end: synchronises and debounces btn_raw, latches the switch
// instruction on each accepted press and emits one-cycle btn_edge / press_drop pulses.
module btn_instr_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        btn_raw,
    input  logic [15:0] sw_instr,
    input  logic        busy,
    output logic [3:0]  opcode,
    output logic [11:0] instr,
    output logic        btn_edge,
    output logic        press_drop,
    output logic        btn_db,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_REL   = 2'd0,
        S_PWAIT = 2'd1,
        S_PRESS = 2'd2,
        S_RWAIT = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [3:0]             opcode_q;
    logic [11:0]            instr_q;
    logic                   btn_edge_q;
    logic                   press_drop_q;
    logic                   btn_db_q;

    // btn_raw is asynchronous; only the last stage is safe to use.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_REL;
            cnt_q        <= '0;
            opcode_q     <= '0;
            instr_q      <= '0;
            btn_edge_q   <= 1'b0;
            press_drop_q <= 1'b0;
            btn_db_q     <= 1'b0;
        end else begin
            btn_edge_q   <= 1'b0;
            press_drop_q <= 1'b0;
            case (state_q)
                S_REL: begin
                    if (btn_s) begin
                        state_q <= S_PWAIT;
                        cnt_q   <= '0;
                    end
                end
                S_PWAIT: begin
                    if (!btn_s) begin
                        state_q <= S_REL;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        // busy and sw_instr matter only on this accept edge.
                        state_q  <= S_PRESS;
                        cnt_q    <= '0;
                        btn_db_q <= 1'b1;
                        if (busy) begin
                            press_drop_q <= 1'b1;
                        end else begin
                            opcode_q   <= sw_instr[3:0];
                            instr_q    <= sw_instr[15:4];
                            btn_edge_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_PRESS: begin
                    if (!btn_s) begin
                        state_q <= S_RWAIT;
                        cnt_q   <= '0;
                    end
                end
                S_RWAIT: begin
                    if (btn_s) begin
                        state_q <= S_PRESS;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= S_REL;
                        cnt_q    <= '0;
                        btn_db_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_REL;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign opcode     = opcode_q;
    assign instr      = instr_q;
    assign btn_edge   = btn_edge_q;
    assign press_drop = press_drop_q;
    assign btn_db     = btn_db_q;
    assign dbg_state  = state_q;

endmodule
